fadd_norm_round: RTL and testbench
==================================

Name: fadd_norm_round

Overview:
- Pipelined normalize-and-round stage directly downstream of the fadd adder datapath in stage3 FUs.
- Consumes the raw aligned sum, with carry, hidden, guard, round and sticky bits, plus the larger operand's biased exponent.
- Produces a packed IEEE-754 result and RISC-V fflags.
- 2-stage pipeline with valid/ready handshake: stage S1 normalizes, stage S2 rounds and packs.

Parameters:
- N, 32, operand width; 32 or 64. Derived localparams: for N=32, E=8 and F=23; for N=64, E=11 and F=52. E is exponent width, F is fraction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight ops
- in_valid  in  1  upstream sum valid
- in_ready  out  1  stage can accept this cycle
- in_sign  in  1  result sign from adder
- in_exp  in  E  biased exponent of larger operand
- in_sum  in  F+4  raw sum: [F+3] carry, [F+2] hidden, [F+1:2] fraction, [1] guard, [0] round
- in_sticky  in  1  OR of bits shifted out during alignment
- in_sub  in  1  effective subtraction (operand signs differed)
- in_frm  in  3  rounding mode
- in_special  in  1  upstream detected NaN/inf case; bypass rounding
- in_special_val  in  N  packed result for the special case
- in_special_flags  in  5  fflags for the special case
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  N  packed IEEE result
- out_fflags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_fflags=0. in_ready=1 once the pipe is empty.
- Handshake:
  - S2 advances when !s2_valid or out_ready.
  - S1 advances when !s1_valid or S2 advances.
  - in_ready = !s1_valid or S2 advances (combinational).
  - Transfer occurs on in_valid & in_ready and on out_valid & out_ready.
  - Latency is 2 cycles when out_ready=1; throughput is 1 op per cycle.
  - While out_valid=1 and out_ready=0, out_result and out_fflags are held stable.
- flush=1: s1_valid and s2_valid clear next edge. An input presented in the same cycle is dropped. flush wins over all transfers.
- S1 normalize:
  - carry=1: shift right 1, shifted-out guard ORs into sticky, exp+1.
  - Else lzc over [F+2:0]. Left shift by min(lzc, exp-1); exp -= shift.
  - If the hidden bit is still 0 after the shift: denormal, exp field 0.
  - Sum and sticky all zero: exact zero. Sign = (frm==RDN) if in_sub, else in_sign.
  - Registers: sign, exp (E+1 bits, to catch overflow), fraction with hidden bit, G, R|S, frm, special fields.
- S2 round: lsb = fraction[0], g = guard, s = round|sticky, inexact = g|s.
  - RNE 000: inc = g & (s|lsb).
  - RTZ 001: inc = 0.
  - RDN 010: inc = sign & inexact.
  - RUP 011: inc = !sign & inexact.
  - RMM 100: inc = g.
  - frm 101–111: treated as RNE (illegal rm trapped at decode).
- Mantissa carry-out after increment: exp+1, fraction = 0. A denormal rounding up into the hidden bit becomes exp=1.
- Overflow (exp ≥ 2^E−1 after rounding): OF|NX set.
  - Result is inf for RNE and RMM; inf for RUP if positive; inf for RDN if negative.
  - Otherwise result is max finite (exp 2^E−2, fraction all ones).
- Flags:
  - NX = inexact or overflow.
  - UF = result tiny (exp field 0 before rounding) and inexact.
  - NV = DZ = 0 except in the special path.
- in_special=1: out_result = in_special_val, out_fflags = in_special_flags, with the same 2-cycle latency.
- Reset mid-operation: all valids clear immediately. Nothing is emitted for in-flight ops after rst_n rises.

Test Plan (N=32):
- 1.0+1.0: exp=0x7F, in_sum carry=1, rest 0, frm=000, out_ready=1 → out_valid 2 cycles later, out_result=0x40000000, fflags=0x00.
- Exact cancellation, in_sub=1, in_sum=0, sticky=0: frm=000 → 0x00000000; frm=010 → 0x80000000; fflags=0x00 for both.
- Tie, exp=0x7F, hidden=1, fraction=0, g=1, r=0, sticky=0:
  - RNE → 0x3F800000, fflags=0x01.
  - RUP → 0x3F800001, fflags=0x01.
  - RMM → 0x3F800001, fflags=0x01.
  - RTZ → 0x3F800000, fflags=0x01.
- Overflow, exp=0xFE, carry=1, sign=0: RNE → 0x7F800000, fflags=0x05; RTZ → 0x7F7FFFFF, fflags=0x05; sign=1 with RUP → 0xFF7FFFFF.
- Backpressure:
  - Issue 4 back-to-back ops with out_ready=0 for 5 cycles → exactly 2 accepted, then in_ready=0.
  - out_result is stable while stalled.
  - After out_ready=1, all 4 results emerge in order, 1 per cycle.
- Flush/reset: with ops in S1 and S2, pulse flush → out_valid=0 next cycle and in_ready=1. Repeat with rst_n=0 mid-op → out_valid and out_result clear immediately, and no stale output after release.

Source files
------------

// File: rtl/fadd_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fadd_norm_round
// Description : Two-stage normalize (S1) and round/pack (S2) stage behind the
//               fadd adder datapath. Produces an IEEE-754 result and RISC-V
//               fflags {NV,DZ,OF,UF,NX} through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_norm_round #(
    parameter int N = 32,
    localparam int E = (N == 64) ? 11 : 8,
    localparam int F = (N == 64) ? 52 : 23
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [E-1:0] in_exp,
    input  logic [F+3:0] in_sum,
    input  logic         in_sticky,
    input  logic         in_sub,
    input  logic [2:0]   in_frm,
    input  logic         in_special,
    input  logic [N-1:0] in_special_val,
    input  logic [4:0]   in_special_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [4:0]   out_fflags
);

    // Normalize window: hidden bit, fraction, guard and round bits.
    localparam int W  = F + 3;
    localparam int LW = $clog2(W + 1);

    localparam logic [E:0] c_EXP_MAX = {1'b0, {E{1'b1}}};
    localparam logic [2:0] c_RTZ     = 3'b001;
    localparam logic [2:0] c_RDN     = 3'b010;
    localparam logic [2:0] c_RUP     = 3'b011;
    localparam logic [2:0] c_RMM     = 3'b100;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_fire;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_in_fire = in_valid && w_s1_adv;
    assign out_valid = r_s2_valid;

    // Pipeline valid bits; flush overrides every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= in_valid;
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // S1: normalize
    // ------------------------------------------------------------------
    logic [W-1:0]  w_norm_in;
    logic [LW-1:0] w_lzc;
    logic [E:0]    w_exp_eff;
    logic [E:0]    w_shift_lim;
    logic [E:0]    w_lzc_ext;
    logic [E:0]    w_shift;
    logic [W-1:0]  w_shifted;

    assign w_norm_in = in_sum[F+2:0];

    // Leading-zero count over the normalize window; the highest set bit wins.
    always_comb begin
        w_lzc = LW'(W);
        for (int i = 0; i < W; i++) begin
            if (w_norm_in[i]) w_lzc = LW'(W - 1 - i);
        end
    end

    // A zero exponent field denotes a denormal whose effective exponent is 1.
    assign w_exp_eff   = (in_exp == '0) ? (E+1)'(1) : {1'b0, in_exp};
    assign w_shift_lim = w_exp_eff - (E+1)'(1);
    assign w_lzc_ext   = (E+1)'(w_lzc);
    assign w_shift     = (w_lzc_ext < w_shift_lim) ? w_lzc_ext : w_shift_lim;
    assign w_shifted   = w_norm_in << w_shift;

    logic         w_n_sign;
    logic [E:0]   w_n_exp;
    logic [F:0]   w_n_mant;
    logic         w_n_g;
    logic         w_n_rs;

    // Select carry right-shift or clamped left-shift, and fix exact-zero sign.
    always_comb begin
        w_n_sign = in_sign;
        w_n_exp  = '0;
        w_n_mant = '0;
        w_n_g    = 1'b0;
        w_n_rs   = 1'b0;
        if (in_sum[F+3]) begin
            w_n_mant = in_sum[F+3:3];
            w_n_g    = in_sum[2];
            w_n_rs   = in_sum[1] | in_sum[0] | in_sticky;
            w_n_exp  = w_exp_eff + (E+1)'(1);
        end else begin
            w_n_mant = w_shifted[W-1:2];
            w_n_g    = w_shifted[1];
            w_n_rs   = w_shifted[0] | in_sticky;
            w_n_exp  = w_shifted[W-1] ? (w_exp_eff - w_shift) : '0;
        end
        if ((in_sum == '0) && !in_sticky && in_sub) begin
            w_n_sign = (in_frm == c_RDN);
        end
    end

    logic         r_s1_sign;
    logic [E:0]   r_s1_exp;
    logic [F:0]   r_s1_mant;
    logic         r_s1_g;
    logic         r_s1_rs;
    logic [2:0]   r_s1_frm;
    logic         r_s1_special;
    logic [N-1:0] r_s1_special_val;
    logic [4:0]   r_s1_special_flags;

    // S1 payload register, loaded on every accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sign          <= 1'b0;
            r_s1_exp           <= '0;
            r_s1_mant          <= '0;
            r_s1_g             <= 1'b0;
            r_s1_rs            <= 1'b0;
            r_s1_frm           <= '0;
            r_s1_special       <= 1'b0;
            r_s1_special_val   <= '0;
            r_s1_special_flags <= '0;
        end else if (w_in_fire && !flush) begin
            r_s1_sign          <= w_n_sign;
            r_s1_exp           <= w_n_exp;
            r_s1_mant          <= w_n_mant;
            r_s1_g             <= w_n_g;
            r_s1_rs            <= w_n_rs;
            r_s1_frm           <= in_frm;
            r_s1_special       <= in_special;
            r_s1_special_val   <= in_special_val;
            r_s1_special_flags <= in_special_flags;
        end
    end

    // ------------------------------------------------------------------
    // S2: round and pack
    // ------------------------------------------------------------------
    logic         w_inexact;
    logic         w_inc;
    logic         w_ovf_inf;
    logic [F+1:0] w_mant_inc;
    logic         w_den_up;
    logic [E:0]   w_exp_rnd;
    logic         w_ovf;
    logic         w_tiny;
    logic [N-1:0] w_result;
    logic [4:0]   w_fflags;

    // Rounding increment and overflow direction per rounding mode.
    always_comb begin
        w_inexact = r_s1_g | r_s1_rs;
        w_inc     = r_s1_g & (r_s1_rs | r_s1_mant[0]);
        w_ovf_inf = 1'b1;
        case (r_s1_frm)
            c_RTZ: begin
                w_inc     = 1'b0;
                w_ovf_inf = 1'b0;
            end
            c_RDN: begin
                w_inc     = r_s1_sign & w_inexact;
                w_ovf_inf = r_s1_sign;
            end
            c_RUP: begin
                w_inc     = !r_s1_sign & w_inexact;
                w_ovf_inf = !r_s1_sign;
            end
            c_RMM: w_inc = r_s1_g;
            default: ;
        endcase
    end

    assign w_mant_inc = {1'b0, r_s1_mant} + {{(F+1){1'b0}}, w_inc};
    // A denormal that rounds into the hidden bit becomes the smallest normal.
    assign w_den_up   = (r_s1_exp == '0) && w_mant_inc[F];
    assign w_exp_rnd  = r_s1_exp + {{E{1'b0}}, w_mant_inc[F+1]} + {{E{1'b0}}, w_den_up};
    assign w_ovf      = (w_exp_rnd >= c_EXP_MAX);
    assign w_tiny     = (r_s1_exp == '0);

    // Pack the final result: special bypass, overflow saturation or normal.
    always_comb begin
        w_result = {r_s1_sign, w_exp_rnd[E-1:0], w_mant_inc[F-1:0]};
        w_fflags = {3'b000, w_tiny & w_inexact, w_inexact};
        if (r_s1_special) begin
            w_result = r_s1_special_val;
            w_fflags = r_s1_special_flags;
        end else if (w_ovf) begin
            w_fflags = 5'b00101;
            if (w_ovf_inf) w_result = {r_s1_sign, {E{1'b1}}, {F{1'b0}}};
            else           w_result = {r_s1_sign, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
        end
    end

    logic [N-1:0] r_out_result;
    logic [4:0]   r_out_fflags;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result <= '0;
            r_out_fflags <= '0;
        end else if (w_s2_adv && r_s1_valid && !flush) begin
            r_out_result <= w_result;
            r_out_fflags <= w_fflags;
        end
    end

    assign out_result = r_out_result;
    assign out_fflags = r_out_fflags;

endmodule
`default_nettype wire

// File: tb/tb_fadd_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_norm_round
// Description : Scoreboard bench for fadd_norm_round (N=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_norm_round;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_sum;
    logic        in_sticky;
    logic        in_sub;
    logic [2:0]  in_frm;
    logic        in_special;
    logic [31:0] in_special_val;
    logic [4:0]  in_special_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;

    fadd_norm_round #(.N(32)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_sign          (in_sign),
        .in_exp           (in_exp),
        .in_sum           (in_sum),
        .in_sticky        (in_sticky),
        .in_sub           (in_sub),
        .in_frm           (in_frm),
        .in_special       (in_special),
        .in_special_val   (in_special_val),
        .in_special_flags (in_special_flags),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_fflags       (out_fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  e;
        logic [26:0] sum;
        logic        sticky;
        logic        sub;
        logic [2:0]  frm;
        logic        sp;
        logic [31:0] spv;
        logic [4:0]  spf;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    vec_t sb[$];
    vec_t vt[$];
    vec_t cur;
    vec_t popped;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [26:0] sum,
                                input logic st, input logic sub, input logic [2:0] frm,
                                input logic [31:0] res, input logic [4:0] fl);
        vec_t v;
        v.sign = s; v.e = e; v.sum = sum; v.sticky = st; v.sub = sub; v.frm = frm;
        v.sp = 1'b0; v.spv = '0; v.spf = '0; v.res = res; v.fl = fl;
        return v;
    endfunction

    // Scoreboard: push on accepted input, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    popped = sb.pop_front();
                    check("result", out_result, popped.res);
                    check("fflags", {27'b0, out_fflags}, {27'b0, popped.fl});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    task automatic drive(input vec_t v);
        cur              = v;
        in_sign          = v.sign;
        in_exp           = v.e;
        in_sum           = v.sum;
        in_sticky        = v.sticky;
        in_sub           = v.sub;
        in_frm           = v.frm;
        in_special       = v.sp;
        in_special_val   = v.spv;
        in_special_flags = v.spf;
        in_valid         = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        logic acc;
        acc = 1'b0;
        drive(v);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t bp[4];
    vec_t sp_v;
    int   idx;
    int   cycles;
    logic acc;
    logic [31:0] snap;

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(mk(0, 8'h00, 27'h0, 0, 0, 3'b000, 32'h0, 5'h0));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_fflags", {27'b0, out_fflags}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: result visible two edges after acceptance.
        issue(mk(0, 8'h7F, 27'h4000000, 0, 0, 3'b000, 32'h40000000, 5'h00));
        check("lat_edge1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2", {31'b0, out_valid}, 32'd1);
        drain();

        vt.push_back(mk(1, 8'h00, 27'h0000000, 0, 1, 3'b000, 32'h00000000, 5'h00));
        vt.push_back(mk(0, 8'h00, 27'h0000000, 0, 1, 3'b010, 32'h80000000, 5'h00));
        vt.push_back(mk(0, 8'h7F, 27'h2000002, 0, 0, 3'b000, 32'h3F800000, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h2000002, 0, 0, 3'b011, 32'h3F800001, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h2000002, 0, 0, 3'b100, 32'h3F800001, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h2000002, 0, 0, 3'b001, 32'h3F800000, 5'h01));
        vt.push_back(mk(0, 8'hFE, 27'h4000000, 0, 0, 3'b000, 32'h7F800000, 5'h05));
        vt.push_back(mk(0, 8'hFE, 27'h4000000, 0, 0, 3'b001, 32'h7F7FFFFF, 5'h05));
        vt.push_back(mk(1, 8'hFE, 27'h4000000, 0, 0, 3'b011, 32'hFF7FFFFF, 5'h05));
        vt.push_back(mk(1, 8'hFE, 27'h4000000, 0, 0, 3'b010, 32'hFF800000, 5'h05));
        vt.push_back(mk(0, 8'h7F, 27'h1000000, 0, 1, 3'b000, 32'h3F000000, 5'h00));
        vt.push_back(mk(0, 8'h7F, 27'h0000008, 0, 1, 3'b000, 32'h34800000, 5'h00));
        vt.push_back(mk(0, 8'h01, 27'h1000000, 0, 0, 3'b000, 32'h00400000, 5'h00));
        vt.push_back(mk(0, 8'h03, 27'h0100000, 0, 1, 3'b000, 32'h00100000, 5'h00));
        vt.push_back(mk(0, 8'h01, 27'h1000002, 0, 0, 3'b000, 32'h00400000, 5'h03));
        vt.push_back(mk(0, 8'h01, 27'h1FFFFFE, 0, 0, 3'b000, 32'h00800000, 5'h03));
        vt.push_back(mk(0, 8'h7F, 27'h3FFFFFE, 0, 0, 3'b011, 32'h40000000, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h4000001, 0, 0, 3'b000, 32'h40000000, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h4000001, 0, 0, 3'b011, 32'h40000001, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h2000000, 1, 0, 3'b011, 32'h3F800001, 5'h01));
        vt.push_back(mk(1, 8'h7F, 27'h2000001, 0, 0, 3'b010, 32'hBF800001, 5'h01));
        vt.push_back(mk(0, 8'h7F, 27'h2000006, 0, 0, 3'b101, 32'h3F800002, 5'h01));
        sp_v = mk(0, 8'hFF, 27'h0, 0, 0, 3'b000, 32'h7FC00000, 5'h10);
        sp_v.sp = 1'b1; sp_v.spv = 32'h7FC00000; sp_v.spf = 5'h10;
        vt.push_back(sp_v);

        // Back-to-back issue of the whole table.
        foreach (vt[i]) issue(vt[i]);
        drain();

        // Backpressure: 4 ops offered while the consumer stalls for 5 cycles.
        bp[0] = mk(0, 8'h7F, 27'h4000000, 0, 0, 3'b000, 32'h40000000, 5'h00);
        bp[1] = mk(0, 8'h80, 27'h4000000, 0, 0, 3'b000, 32'h40800000, 5'h00);
        bp[2] = mk(0, 8'h81, 27'h4000000, 0, 0, 3'b000, 32'h41000000, 5'h00);
        bp[3] = mk(0, 8'h82, 27'h4000000, 0, 0, 3'b000, 32'h41800000, 5'h00);
        out_ready = 1'b0;
        idx = 0;
        snap = '0;
        for (int c = 0; c < 5; c++) begin
            drive(bp[idx]);
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (c == 2) snap = out_result;
        end
        check("bp_accepted", idx, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold", out_result, snap);
        out_ready = 1'b1;
        cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 4) drive(bp[idx]);
            else in_valid = 1'b0;
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cycles++;
            if (idx == 4 && sb.size() == 0) break;
        end
        in_valid = 1'b0;
        check("bp_drain_cycles", cycles, 32'd4);

        // Flush with ops in S1 and S2 plus a simultaneous input.
        out_ready = 1'b0;
        issue(bp[0]);
        issue(bp[1]);
        drive(bp[2]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_quiet", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        issue(bp[3]);
        issue(bp[1]);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_out_result", out_result, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_quiet", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);

        // Pipe still operates after reset.
        issue(vt[3]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
